// File: rtl/rr_bus_arbiter4.sv
// rr_bus_arbiter4 -- four-requester round-robin bus arbiter.
// Samples active-low requests, issues one active-low grant at a time, and
// drives the matching 2-to-4 decoder select/enable so downstream decode and
// grant lines always agree. Each grant is followed by one RELEASE cycle and
// one IDLE cycle before the next grant can be issued.
// Optional feature: define ARB_TIMEOUT_EN to bound each grant to MAX_HOLD
// cycles (forced release, one-cycle TIMEOUT pulse). Without it TIMEOUT is 0
// and a grant is held until DONE or withdrawal.

module rr_bus_arbiter4 #(
    parameter int MAX_HOLD = 15
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] REQ_L,
    input  logic       DONE,
    output logic [3:0] GNT_L,
    output logic [1:0] SEL,
    output logic       EN_L,
    output logic       BUSY,
    output logic       TIMEOUT
);

    // Reject configurations outside the supported hold range at elaboration.
    if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_max_hold
        $error("rr_bus_arbiter4: MAX_HOLD must be within 2..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT   = 2'b01,
        ST_RELEASE = 2'b10
    } state_t;

    state_t     r_state;
    logic [1:0] r_ptr;
    logic [1:0] r_sel;
    logic [3:0] r_gnt_l;
    logic       r_en_l;
    logic       r_busy;

    state_t     w_state_nxt;
    logic [1:0] w_ptr_nxt;
    logic [1:0] w_sel_nxt;
    logic [3:0] w_gnt_l_nxt;
    logic       w_en_l_nxt;
    logic       w_busy_nxt;

    logic [3:0] w_req;
    logic [7:0] w_req_dbl;
    logic [7:0] w_req_shift;
    logic [3:0] w_req_rot;
    logic [1:0] w_off;
    logic [1:0] w_winner;
    logic       w_any_req;
    logic       w_release;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

    logic [7:0] r_hc;
    logic       r_timeout;
    logic [7:0] w_hc_nxt;
    logic       w_timeout_nxt;
`endif

    // Requests rotated so bit j is requester (PTR+j) mod 4; the lowest set
    // bit is then the first requester in round-robin search order.
    always_comb begin
        w_req       = ~REQ_L;
        w_req_dbl   = {w_req, w_req};
        w_req_shift = w_req_dbl >> r_ptr;
        w_req_rot   = w_req_shift[3:0];
        w_any_req   = |w_req;
        casez (w_req_rot)
            4'b???1: w_off = 2'd0;
            4'b??10: w_off = 2'd1;
            4'b?100: w_off = 2'd2;
            4'b1000: w_off = 2'd3;
            default: w_off = 2'd0;
        endcase
        w_winner  = r_ptr + w_off;
        w_release = DONE | REQ_L[r_sel];
    end

    // Next-state and next-output computation for the IDLE/GRANT/RELEASE FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_gnt_l_nxt = 4'b1111;
        w_en_l_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        w_hc_nxt      = r_hc;
        w_timeout_nxt = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_GRANT;
                    w_sel_nxt   = w_winner;
                    w_gnt_l_nxt = ~(4'b0001 << w_winner);
                    w_en_l_nxt  = 1'b0;
                    w_busy_nxt  = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    w_hc_nxt    = 8'd0;
`endif
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // A genuine release wins over a simultaneous timeout.
                if (w_release) begin
                    w_state_nxt = ST_RELEASE;
                    w_ptr_nxt   = r_sel + 2'd1;
                    w_busy_nxt  = 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (r_hc == HOLD_LIMIT) begin
                    w_state_nxt   = ST_RELEASE;
                    w_ptr_nxt     = r_sel + 2'd1;
                    w_busy_nxt    = 1'b1;
                    w_timeout_nxt = 1'b1;
                end
`endif
                else begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_l_nxt = ~(4'b0001 << r_sel);
                    w_en_l_nxt  = 1'b0;
                    w_busy_nxt  = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    if (r_hc != 8'hFF) begin
                        w_hc_nxt = r_hc + 8'd1;
                    end else begin
                        w_hc_nxt = r_hc;
                    end
`endif
                end
            end
            ST_RELEASE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; synchronous reset overrides everything.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd0;
            r_sel   <= 2'd0;
            r_gnt_l <= 4'b1111;
            r_en_l  <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_gnt_l <= w_gnt_l_nxt;
            r_en_l  <= w_en_l_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Hold counter and the one-cycle forced-release indicator.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_hc      <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_hc      <= w_hc_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign TIMEOUT = r_timeout;
`else
    assign TIMEOUT = 1'b0;
`endif

    assign GNT_L = r_gnt_l;
    assign SEL   = r_sel;
    assign EN_L  = r_en_l;
    assign BUSY  = r_busy;

endmodule

// File: tb/tb_rr_bus_arbiter4.sv
// Directed self-checking bench for rr_bus_arbiter4.
// With ARB_TIMEOUT_EN defined it checks the MAX_HOLD=4 forced release;
// otherwise it checks that a grant persists with TIMEOUT held low.

module tb_rr_bus_arbiter4;

    logic       CLK;
    logic       RESET;
    logic [3:0] REQ_L;
    logic       DONE;
    logic [3:0] GNT_L;
    logic [1:0] SEL;
    logic       EN_L;
    logic       BUSY;
    logic       TIMEOUT;

    int checks;
    int failures;

    logic [3:0] rr_gnt [5];
    logic [1:0] rr_sel [5];

    rr_bus_arbiter4 #(
        .MAX_HOLD(4)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .REQ_L  (REQ_L),
        .DONE   (DONE),
        .GNT_L  (GNT_L),
        .SEL    (SEL),
        .EN_L   (EN_L),
        .BUSY   (BUSY),
        .TIMEOUT(TIMEOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] gnt, input logic en,
                           input logic [1:0] sel, input logic busy);
        check({tag, ".gnt"},  {4'd0, GNT_L}, {4'd0, gnt});
        check({tag, ".en"},   {7'd0, EN_L},  {7'd0, en});
        check({tag, ".sel"},  {6'd0, SEL},   {6'd0, sel});
        check({tag, ".busy"}, {7'd0, BUSY},  {7'd0, busy});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rr_gnt[0] = 4'b1110; rr_sel[0] = 2'd0;
        rr_gnt[1] = 4'b1101; rr_sel[1] = 2'd1;
        rr_gnt[2] = 4'b1011; rr_sel[2] = 2'd2;
        rr_gnt[3] = 4'b0111; rr_sel[3] = 2'd3;
        rr_gnt[4] = 4'b1110; rr_sel[4] = 2'd0;

        // Power-up reset
        RESET = 1'b1; REQ_L = 4'b1111; DONE = 1'b0;
        step(); step();
        chk_out("rst", 4'b1111, 1'b1, 2'd0, 1'b0);
        check("rst.to", {7'd0, TIMEOUT}, 8'd0);

        // Reset in the middle of a grant to requester 2
        RESET = 1'b0; REQ_L = 4'b1011;
        step();
        chk_out("own2", 4'b1011, 1'b0, 2'd2, 1'b1);
        RESET = 1'b1;
        step();
        chk_out("rst_mid", 4'b1111, 1'b1, 2'd0, 1'b0);
        step();
        RESET = 1'b0; REQ_L = 4'b0110;
        step();
        chk_out("ptr0", 4'b1110, 1'b0, 2'd0, 1'b1);
        DONE = 1'b1; REQ_L = 4'b1111;
        step();
        DONE = 1'b0;
        chk_out("ptr0_rel", 4'b1111, 1'b1, 2'd0, 1'b1);
        step();
        chk_out("ptr0_idle", 4'b1111, 1'b1, 2'd0, 1'b0);

        // Single requester 0 (pointer is now 1, search wraps to 0)
        REQ_L = 4'b1110;
        step();
        chk_out("single", 4'b1110, 1'b0, 2'd0, 1'b1);
        step();
        chk_out("single_hold", 4'b1110, 1'b0, 2'd0, 1'b1);
        DONE = 1'b1;
        step();
        DONE = 1'b0; REQ_L = 4'b1111;
        chk_out("single_rel", 4'b1111, 1'b1, 2'd0, 1'b1);
        step();
        chk_out("single_idle", 4'b1111, 1'b1, 2'd0, 1'b0);

        // Round robin from pointer 0 with all requesting, DONE in 3rd cycle
        RESET = 1'b1;
        step();
        RESET = 1'b0; REQ_L = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_out($sformatf("rr%0d.g1", k), rr_gnt[k], 1'b0, rr_sel[k], 1'b1);
            step();
            chk_out($sformatf("rr%0d.g2", k), rr_gnt[k], 1'b0, rr_sel[k], 1'b1);
            step();
            chk_out($sformatf("rr%0d.g3", k), rr_gnt[k], 1'b0, rr_sel[k], 1'b1);
            DONE = 1'b1;
            step();
            DONE = 1'b0;
            chk_out($sformatf("rr%0d.rel", k), 4'b1111, 1'b1, rr_sel[k], 1'b1);
            step();
            chk_out($sformatf("rr%0d.idle", k), 4'b1111, 1'b1, rr_sel[k], 1'b0);
        end
        REQ_L = 4'b1111;

        // Pointer is 1; grant requester 2 to move it to 3
        REQ_L = 4'b1011;
        step();
        chk_out("pre2", 4'b1011, 1'b0, 2'd2, 1'b1);
        DONE = 1'b1; REQ_L = 4'b1111;
        step();
        DONE = 1'b0;
        step();

        // Wrap and skip: pointer 3, requesters 0 and 2
        REQ_L = 4'b1010;
        step();
        chk_out("wrap", 4'b1110, 1'b0, 2'd0, 1'b1);
        DONE = 1'b1;
        step();
        DONE = 1'b0;
        chk_out("wrap_rel", 4'b1111, 1'b1, 2'd0, 1'b1);
        step();
        step();
        chk_out("skip", 4'b1011, 1'b0, 2'd2, 1'b1);

        // Release owner 2 (pointer 3), then a stray DONE in IDLE is ignored
        DONE = 1'b1; REQ_L = 4'b1111;
        step();
        DONE = 1'b0;
        step();
        DONE = 1'b1;
        step();
        DONE = 1'b0;
        chk_out("done_idle", 4'b1111, 1'b1, 2'd2, 1'b0);

        // Withdrawal by owner 1, pointer must become 2
        REQ_L = 4'b1101;
        step();
        chk_out("own1", 4'b1101, 1'b0, 2'd1, 1'b1);
        REQ_L = 4'b1111;
        step();
        chk_out("wd_rel", 4'b1111, 1'b1, 2'd1, 1'b1);
        step();
        REQ_L = 4'b1001;
        step();
        chk_out("ptr2", 4'b1011, 1'b0, 2'd2, 1'b1);

        // Release owner 2 (pointer 3), then requester 3 holds without DONE
        DONE = 1'b1; REQ_L = 4'b1111;
        step();
        DONE = 1'b0;
        step();
        REQ_L = 4'b0111;
        step();
        chk_out("own3", 4'b0111, 1'b0, 2'd3, 1'b1);
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i < 4; i++) begin
            step();
            chk_out($sformatf("hold%0d", i), 4'b0111, 1'b0, 2'd3, 1'b1);
            check($sformatf("hold%0d.to", i), {7'd0, TIMEOUT}, 8'd0);
        end
        step();
        chk_out("to_rel", 4'b1111, 1'b1, 2'd3, 1'b1);
        check("to_rel.to", {7'd0, TIMEOUT}, 8'd1);
        step();
        chk_out("to_idle", 4'b1111, 1'b1, 2'd3, 1'b0);
        check("to_idle.to", {7'd0, TIMEOUT}, 8'd0);
`else
        for (int i = 0; i < 100; i++) begin
            step();
            check($sformatf("persist%0d.gnt", i), {4'd0, GNT_L}, 8'h07);
            check($sformatf("persist%0d.to", i), {7'd0, TIMEOUT}, 8'd0);
        end
`endif
        REQ_L = 4'b1111;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
